// File: rtl/conv11_output_pack.sv
// -----------------------------------------------------------------------------
// conv11_output_pack
//
// Purpose:
//   Collects a stream of per-channel 1x1-convolution results, one channel per
//   beat in channel order 0..CH_NUM-1. It packs each complete pixel into one
//   wide word and queues the words in a first-word-fall-through FIFO.
//
// Parameters:
//   OUT_WIDTH  bit width of one channel result
//   CH_NUM     channel results per packed word (1..16)
//   DEPTH      FIFO depth in packed words (power of two, >= 2)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data carries one channel result
//   in_data     channel result (OUT_WIDTH bits)
//   in_ready    block accepts in_data this cycle
//   out_valid   out_data holds the oldest packed word
//   out_data    packed word, channel k at [k*OUT_WIDTH +: OUT_WIDTH];
//               zero while out_valid is low
//   out_ready   consumer takes out_data this cycle
//   count       packed words currently stored
//   pixel_done  one-cycle pulse the cycle after a word is committed
//
// Build option:
//   CONV11_OUTPUT_PACK_RELU_EN  when defined, in_data is treated as signed.
//                               A negative value is stored as zero.
// -----------------------------------------------------------------------------
module conv11_output_pack #(
  parameter int OUT_WIDTH = 8,
  parameter int CH_NUM    = 4,
  parameter int DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [OUT_WIDTH-1:0]          in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [CH_NUM*OUT_WIDTH-1:0]   out_data,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          pixel_done
);

  // A single-channel build still needs a 1-bit counter to keep widths legal.
  localparam int CW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int WW   = CH_NUM * OUT_WIDTH;

  localparam logic [CW-1:0]   LAST_CH = CW'(CH_NUM - 1);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]   r_ch_cnt;
  logic [WW-1:0]   r_asm;            // partially assembled pixel, not reset
  logic [WW-1:0]   r_mem [DEPTH];    // FIFO storage, not reset
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_pixel_done;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic            w_last_ch;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_commit;
  logic            w_out_valid;
  logic            w_pop;
  logic [OUT_WIDTH-1:0] w_lane;
  logic [WW-1:0]   w_word;

  assign w_last_ch  = (r_ch_cnt == LAST_CH);

  // Only the beat that completes a pixel needs a free FIFO slot. in_ready
  // looks at the registered count only. A pop in this cycle frees a slot
  // only on the next cycle. This keeps out_ready off the in_ready path.
  assign w_in_ready = !w_last_ch || (r_count < DEPTH_C);

  assign w_accept   = in_valid && w_in_ready;
  assign w_commit   = w_accept && w_last_ch;

  // Gating with rst makes the output read as empty during the reset cycle
  // itself, and not only after the first reset edge.
  assign w_out_valid = (r_count != '0) && !rst;
  assign w_pop       = w_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Lane value: optional clamp of negative results to zero
  // ---------------------------------------------------------------------------
`ifdef CONV11_OUTPUT_PACK_RELU_EN
  assign w_lane = in_data[OUT_WIDTH-1] ? '0 : in_data;
`else
  assign w_lane = in_data;
`endif

  // ---------------------------------------------------------------------------
  // Word assembly: the current beat replaces its own lane and every other
  // lane keeps the stored value. w_word feeds both the assembly register
  // and, on the last channel, the FIFO. The completed pixel therefore
  // includes the beat that finishes it.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
      assign w_word[gi*OUT_WIDTH +: OUT_WIDTH] =
        (r_ch_cnt == CW'(gi)) ? w_lane : r_asm[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_asm <= w_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_cnt <= '0;
    end else if (w_accept) begin
      if (w_last_ch) begin
        r_ch_cnt <= '0;
      end else begin
        r_ch_cnt <= r_ch_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage. The write port has no reset so that the array can map
  // onto memory resources.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and commit pulse. DEPTH is a power of two, so
  // the pointers wrap from DEPTH-1 to 0 through natural overflow.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pixel_done <= 1'b0;
    end else begin
      r_pixel_done <= w_commit;

      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      unique case ({w_commit, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The read is first-word-fall-through: the head word is visible
  // as soon as it is stored, and the bus is forced to zero when empty.
  // ---------------------------------------------------------------------------
  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign count      = r_count;
  assign pixel_done = r_pixel_done;

endmodule

// File: tb/tb_conv11_output_pack.sv
// -----------------------------------------------------------------------------
// tb_conv11_output_pack
//
// Purpose:
//   Directed self-checking bench for conv11_output_pack with OUT_WIDTH=8,
//   CH_NUM=4 and DEPTH=4. Inputs are driven 1 ns after a rising edge and
//   outputs are sampled at that same point.
//
// Scenarios:
//   - packing
//   - full and drain
//   - commit and pop in the same cycle across the pointer wrap
//   - reset in mid-pixel
//   - negative-value clamp (expected values follow the same build macro)
//   - idle and reset checks
// -----------------------------------------------------------------------------
module tb_conv11_output_pack;

  localparam int OW = 8;
  localparam int CN = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [OW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [CN*OW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;
  logic          pixel_done;

  int total = 0;
  int bad   = 0;

  conv11_output_pack #(
    .OUT_WIDTH(OW),
    .CH_NUM   (CN),
    .DEPTH    (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .pixel_done(pixel_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted, within a bounded wait.
  task automatic send_beat(input logic [7:0] d);
    int waited;
    logic accepted;
    waited   = 0;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      accepted = in_ready;
      step();
      waited++;
    end
    in_valid = 1'b0;
    check("beat_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic send_pixel(input logic [31:0] w);
    for (int k = 0; k < CN; k++) begin
      send_beat(w[k*8 +: 8]);
    end
  endtask

  logic [31:0] px [5];
  logic [31:0] relu_exp;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_count",      {29'd0, count}, 32'd0);
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_data",   out_data, 32'd0);
    check("rst_pixel_done", {31'd0, pixel_done}, 32'd0);
    rst = 1'b0;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic packing
    out_ready = 1'b1;
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_out_data",  out_data, 32'd0);
    send_beat(8'h44);
    check("pack_out_valid",  {31'd0, out_valid}, 32'd1);
    check("pack_out_data",   out_data, 32'h44332211);
    check("pack_pixel_done", {31'd0, pixel_done}, 32'd1);
    check("pack_count",      {29'd0, count}, 32'd1);
    step();
    check("pack_count_after_pop", {29'd0, count}, 32'd0);
    check("pack_done_cleared",    {31'd0, pixel_done}, 32'd0);
    check("pack_empty_data",      out_data, 32'd0);

    // Full and drain
    out_ready = 1'b0;
    px[0] = 32'h13121110;
    px[1] = 32'h23222120;
    px[2] = 32'h33323130;
    px[3] = 32'h43424140;
    px[4] = 32'h53525150;
    for (int p = 0; p < 4; p++) send_pixel(px[p]);
    check("full_count", {29'd0, count}, 32'd4);
    send_beat(px[4][7:0]);
    send_beat(px[4][15:8]);
    send_beat(px[4][23:16]);
    check("full_in_ready_ch3", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b1;
    in_data   = px[4][31:24];
    out_ready = 1'b1;
    check("full_stall_with_pop_req", {31'd0, in_ready}, 32'd0);
    check("drain_word0", out_data, px[0]);
    step();   // first pop; the stalled beat is still waiting
    check("drain_word1",        out_data, px[1]);
    check("drain_count_a",      {29'd0, count}, 32'd3);
    check("drain_in_ready",     {31'd0, in_ready}, 32'd1);
    check("drain_no_commit_yet",{31'd0, pixel_done}, 32'd0);
    step();   // stalled beat accepted, and a pop in the same cycle
    in_valid = 1'b0;
    check("drain_word2",        out_data, px[2]);
    check("drain_count_b",      {29'd0, count}, 32'd3);
    check("drain_late_commit",  {31'd0, pixel_done}, 32'd1);
    step();
    check("drain_word3",        out_data, px[3]);
    step();
    check("drain_word4",        out_data, px[4]);
    step();
    check("drain_empty_valid",  {31'd0, out_valid}, 32'd0);
    check("drain_empty_data",   out_data, 32'd0);
    out_ready = 1'b0;

    // Commit and pop in the same cycle at count=2, crossing the pointer wrap
    px[0] = 32'hA3A2A1A0;
    px[1] = 32'hB3B2B1B0;
    px[2] = 32'hC3C2C1C0;
    px[3] = 32'hD3D2D1D0;
    for (int p = 0; p < 3; p++) send_pixel(px[p]);
    send_beat(px[3][7:0]);
    send_beat(px[3][15:8]);
    send_beat(px[3][23:16]);
    check("sim_count_3", {29'd0, count}, 32'd3);
    check("sim_head_a",  out_data, px[0]);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("sim_count_2", {29'd0, count}, 32'd2);
    in_valid  = 1'b1;
    in_data   = px[3][31:24];
    out_ready = 1'b1;
    check("sim_head_b",     out_data, px[1]);
    check("sim_in_ready",   {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("sim_count_hold", {29'd0, count}, 32'd2);
    check("sim_head_c",     out_data, px[2]);
    check("sim_pixel_done", {31'd0, pixel_done}, 32'd1);
    step();
    check("sim_head_d_wrap", out_data, px[3]);
    check("sim_count_1",     {29'd0, count}, 32'd1);
    step();
    check("sim_count_0",     {29'd0, count}, 32'd0);
    out_ready = 1'b0;

    // Reset in mid-pixel
    send_beat(8'hAA);
    send_beat(8'hBB);
    rst = 1'b1;
    step();
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send_pixel(32'h04030201);
    check("mid_rst_data",  out_data, 32'h04030201);
    check("mid_rst_count1",{29'd0, count}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Negative-value clamp
`ifdef CONV11_OUTPUT_PACK_RELU_EN
    relu_exp = 32'h01007F00;
`else
    relu_exp = 32'h01FF7F80;
`endif
    send_pixel(32'h01FF7F80);
    check("relu_data", out_data, relu_exp);
    out_ready = 1'b1;
    step();
    check("relu_popped_valid", {31'd0, out_valid}, 32'd0);
    check("relu_popped_data",  out_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv11_output_pack.md
CONV11_OUTPUT_PACK -- requirements
Module: conv11_output_pack

Interface
REQ-001 Parameter OUT_WIDTH, default 8, bit width of one channel result.
REQ-002 Parameter CH_NUM, default 4, number of channel results packed into one output word (range 1..16).
REQ-003 Parameter DEPTH, default 16, number of packed words the FIFO holds (power of two, at least 2).
REQ-004 Port clk  input  1  single clock; every register is updated on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port in_valid  input  1  in_data carries one channel result this cycle.
REQ-007 Port in_data  input  OUT_WIDTH  one channel result, channels arriving in order 0..CH_NUM-1.
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port out_valid  output  1  out_data holds the oldest packed word.
REQ-010 Port out_data  output  CH_NUM*OUT_WIDTH  packed word; channel k occupies bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-011 Port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 Port count  output  $clog2(DEPTH)+1  number of packed words currently stored in the FIFO.
REQ-013 Port pixel_done  output  1  one-cycle pulse raised the cycle after a packed word is committed to the FIFO.

Function
REQ-014 An input beat is accepted when in_valid and in_ready are both high; in_valid with in_ready low is a stall, and the source holds in_data stable until the beat is accepted.
REQ-015 Channel counter ch_cnt starts at 0, increments on each accepted beat, and wraps from CH_NUM-1 to 0.
REQ-016 An accepted beat writes its lane ch_cnt in an assembly register.
REQ-017 The beat accepted at ch_cnt = CH_NUM-1 commits the completed assembly word, including that beat, into the FIFO at wr_ptr on the same edge.
REQ-018 in_ready = (ch_cnt != CH_NUM-1) OR (count < DEPTH); there is no combinational path from out_ready to in_ready.
REQ-019 The FIFO is first-word-fall-through: out_valid = (count != 0), and out_data = mem[rd_ptr] while out_valid is high.
REQ-020 out_data is all zeros while out_valid is low.
REQ-021 A pop occurs when out_valid and out_ready are both high; rd_ptr then advances.
REQ-022 wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
REQ-023 count update: +1 on commit only, -1 on pop only, unchanged on simultaneous commit and pop, unchanged when neither occurs.
REQ-024 Commit latency: a commit at edge T into an empty FIFO gives out_valid high in the cycle following T.
REQ-025 When the FIFO is full and a pop occurs, a pending last-channel beat still stalls that cycle and is accepted on the next cycle.
REQ-026 pixel_done is a registered pulse, high exactly one cycle after each commit.

Reset
REQ-027 While rst is high: ch_cnt, wr_ptr, rd_ptr, count and pixel_done go to 0, out_valid goes low, and out_data reads as 0.
REQ-028 FIFO memory contents and the assembly register are not reset.
REQ-029 Reset in mid-pixel discards the partial pixel, and the next accepted beat is channel 0.
REQ-030 in_ready is high in the first cycle after rst deasserts.

Configuration
REQ-031 With macro CONV11_OUTPUT_PACK_RELU_EN defined, each accepted in_data is treated as two's-complement signed, and a negative value is written to its lane as 0.
REQ-032 Without CONV11_OUTPUT_PACK_RELU_EN, in_data is written to its lane unchanged; no other behaviour differs between the two builds.

Verification
Bench parameters for all scenarios: OUT_WIDTH=8, CH_NUM=4, DEPTH=4.
REQ-033 Basic packing: beats 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> out_valid high with out_data=0x44332211 one cycle after the 0x44 beat, pixel_done pulses once, count returns to 0 after the pop.
REQ-034 Full and drain: out_ready=0 while 4 pixels are pushed -> count=4, in_ready low when ch_cnt=3 and the 5th pixel's last beat stalls; out_ready=1 then -> words pop in push order and the stalled beat is accepted one cycle after the first pop.
REQ-035 Simultaneous commit and pop at count=2 -> count stays 2, and the next pops return the correct order across the pointer wrap.
REQ-036 Reset mid-pixel: rst pulsed after beats 0xAA, 0xBB, then beats 0x01, 0x02, 0x03, 0x04 -> out_data=0x04030201, with no trace of 0xAA or 0xBB.
REQ-037 ReLU: beats 0x80, 0x7F, 0xFF, 0x01 -> out_data=0x01007F00 with CONV11_OUTPUT_PACK_RELU_EN defined, 0x01FF7F80 without it.
REQ-038 Idle checks: out_data=0 whenever out_valid is low, and in_ready is high in the first cycle after reset.
